// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - ID-stage hazard detector with multi-cycle stall FSM and perf counters
module hazard_ctrl_unit #(
    parameter int REG_AW    = 5,
    parameter int LU_CYCLES = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_reg_write_i,
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_mem_read_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic              id_is_branch_i,
    input  logic              id_branch_taken_i,
    input  logic              icache_stall_i,
    input  logic              dcache_stall_i,
    input  logic              cnt_clr_i,
    output logic              pc_write_o,
    output logic              if_id_write_o,
    output logic              if_id_flush_o,
    output logic              id_ex_bubble_o,
    output logic              freeze_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  freeze_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    // Countdown must hold the longest stall, LU_CYCLES+1.
    localparam int NW = $clog2(LU_CYCLES + 2);

    typedef enum logic {RUN, STALL} state_t;

    state_t          state, state_nxt;
    logic [NW-1:0]   cnt, cnt_nxt;
    logic [NW-1:0]   n_req;
    logic            m_ex, m_mem;
    logic            hazard;
    logic            inc_stall, inc_freeze, inc_flush;

    assign m_ex  = (ex_rd_i != '0) &
                   ((id_use_rs1_i & (ex_rd_i == id_rs1_i)) |
                    (id_use_rs2_i & (ex_rd_i == id_rs2_i)));
    assign m_mem = (mem_rd_i != '0) &
                   ((id_use_rs1_i & (mem_rd_i == id_rs1_i)) |
                    (id_use_rs2_i & (mem_rd_i == id_rs2_i)));

    // Largest applicable stall length; the single-cycle terms only matter when nothing longer applies.
    always_comb begin
        n_req = '0;
        if (ex_mem_read_i & m_ex)
            n_req = NW'(LU_CYCLES);
        if (id_is_branch_i & ex_mem_read_i & m_ex)
            n_req = NW'(LU_CYCLES + 1);
        if ((n_req == '0) & id_is_branch_i &
            ((ex_reg_write_i & ~ex_mem_read_i & m_ex) | (mem_mem_read_i & m_mem)))
            n_req = NW'(1);
    end

    assign hazard = (state == STALL) | (n_req != '0);

    always_comb begin
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        freeze_o       = 1'b0;
        inc_stall      = 1'b0;
        inc_freeze     = 1'b0;
        inc_flush      = 1'b0;
        state_nxt      = state;
        cnt_nxt        = cnt;
        if (rst) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_bubble_o = 1'b1;
        end else if (dcache_stall_i) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            freeze_o      = 1'b1;
            inc_freeze    = 1'b1;
        end else begin
            if (hazard) begin
                pc_write_o     = 1'b0;
                if_id_write_o  = 1'b0;
                id_ex_bubble_o = 1'b1;
                inc_stall      = 1'b1;
            end else if (id_branch_taken_i) begin
                if_id_flush_o = 1'b1;
                inc_flush     = 1'b1;
            end else if (icache_stall_i) begin
                pc_write_o    = 1'b0;
                if_id_flush_o = 1'b1;
            end
            if (state == RUN) begin
                if (n_req > NW'(1)) begin
                    cnt_nxt   = n_req - NW'(1);
                    state_nxt = STALL;
                end
            end else if (cnt == NW'(1)) begin
                cnt_nxt   = '0;
                state_nxt = RUN;
            end else begin
                cnt_nxt = cnt - NW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en & ~(&v)) ? v + 1'b1 : v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst | cnt_clr_i) begin
            stall_cnt_o  <= '0;
            freeze_cnt_o <= '0;
            flush_cnt_o  <= '0;
        end else begin
            stall_cnt_o  <= sat_inc(stall_cnt_o, inc_stall);
            freeze_cnt_o <= sat_inc(freeze_cnt_o, inc_freeze);
            flush_cnt_o  <= sat_inc(flush_cnt_o, inc_flush);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - directed bench for hazard_ctrl_unit (LU_CYCLES=1/CNT_W=3 and LU_CYCLES=2/CNT_W=16)
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] ex_rd, mem_rd, id_rs1, id_rs2;
    logic       ex_reg_write, ex_mem_read, mem_mem_read;
    logic       id_use_rs1, id_use_rs2, id_is_branch, id_branch_taken;
    logic       icache_stall, dcache_stall, cnt_clr;

    logic        pcw1, ifw1, fl1, bub1, frz1;
    logic        pcw2, ifw2, fl2, bub2, frz2;
    logic [2:0]  scnt1, fzcnt1, flcnt1;
    logic [15:0] scnt2, fzcnt2, flcnt2;
    logic [4:0]  ctl1, ctl2;

    // ctl = {pc_write, if_id_write, if_id_flush, id_ex_bubble, freeze}
    assign ctl1 = {pcw1, ifw1, fl1, bub1, frz1};
    assign ctl2 = {pcw2, ifw2, fl2, bub2, frz2};

    localparam logic [4:0] C_NORM  = 5'b11000;
    localparam logic [4:0] C_STALL = 5'b00010;
    localparam logic [4:0] C_FRZ   = 5'b00001;
    localparam logic [4:0] C_REDIR = 5'b11100;
    localparam logic [4:0] C_FBUB  = 5'b01100;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_ctrl_unit #(.REG_AW(5), .LU_CYCLES(1), .CNT_W(3)) u_lu1 (
        .clk(clk), .rst(rst), .ex_rd_i(ex_rd), .ex_reg_write_i(ex_reg_write),
        .ex_mem_read_i(ex_mem_read), .mem_rd_i(mem_rd), .mem_mem_read_i(mem_mem_read),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
        .id_is_branch_i(id_is_branch), .id_branch_taken_i(id_branch_taken),
        .icache_stall_i(icache_stall), .dcache_stall_i(dcache_stall), .cnt_clr_i(cnt_clr),
        .pc_write_o(pcw1), .if_id_write_o(ifw1), .if_id_flush_o(fl1), .id_ex_bubble_o(bub1),
        .freeze_o(frz1), .stall_cnt_o(scnt1), .freeze_cnt_o(fzcnt1), .flush_cnt_o(flcnt1)
    );

    hazard_ctrl_unit #(.REG_AW(5), .LU_CYCLES(2), .CNT_W(16)) u_lu2 (
        .clk(clk), .rst(rst), .ex_rd_i(ex_rd), .ex_reg_write_i(ex_reg_write),
        .ex_mem_read_i(ex_mem_read), .mem_rd_i(mem_rd), .mem_mem_read_i(mem_mem_read),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
        .id_is_branch_i(id_is_branch), .id_branch_taken_i(id_branch_taken),
        .icache_stall_i(icache_stall), .dcache_stall_i(dcache_stall), .cnt_clr_i(cnt_clr),
        .pc_write_o(pcw2), .if_id_write_o(ifw2), .if_id_flush_o(fl2), .id_ex_bubble_o(bub2),
        .freeze_o(frz2), .stall_cnt_o(scnt2), .freeze_cnt_o(fzcnt2), .flush_cnt_o(flcnt2)
    );

    task automatic idle();
        ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0; mem_rd = 0; mem_mem_read = 0;
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_is_branch = 0;
        id_branch_taken = 0; icache_stall = 0; dcache_stall = 0; cnt_clr = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
    endtask

    task automatic branch_load_hazard();
        id_is_branch = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        @(negedge clk);
        n_cmp++;
        if (ctl1 !== C_STALL || ctl2 !== C_STALL) begin
            $display("FAIL reset_outputs: got %b/%b expected %b", ctl1, ctl2, C_STALL); n_bad++;
        end
        step();
        @(negedge clk);
        n_cmp++;
        if ({scnt1, fzcnt1, flcnt1} !== 9'd0 || {scnt2, fzcnt2, flcnt2} !== 48'd0) begin
            $display("FAIL reset_counters: got %0d %0d %0d / %0d %0d %0d expected all 0",
                     scnt1, fzcnt1, flcnt1, scnt2, fzcnt2, flcnt2); n_bad++;
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ctl1 !== C_NORM || ctl2 !== C_NORM) begin
            $display("FAIL post_reset_normal: got %b/%b expected %b", ctl1, ctl2, C_NORM); n_bad++;
        end
        step();
    endtask

    task automatic test_load_use();
        logic [4:0] e1 [3];
        logic [4:0] e2 [3];
        e1 = '{C_STALL, C_NORM, C_NORM};
        e2 = '{C_STALL, C_STALL, C_NORM};
        do_reset();
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ctl1 !== e1[i] || ctl2 !== e2[i]) begin
                $display("FAIL load_use_c%0d: got %b/%b expected %b/%b", i, ctl1, ctl2, e1[i], e2[i]); n_bad++;
            end
            step();
            idle();
        end
        @(negedge clk);
        n_cmp++;
        if (scnt1 !== 3'd1 || scnt2 !== 16'd2) begin
            $display("FAIL load_use_cnt: got %0d/%0d expected 1/2", scnt1, scnt2); n_bad++;
        end
    endtask

    task automatic test_no_hazard();
        do_reset();
        ex_mem_read = 1; ex_rd = 0; id_rs2 = 0; id_use_rs2 = 1;
        @(negedge clk);
        n_cmp++;
        if (ctl1 !== C_NORM || ctl2 !== C_NORM) begin
            $display("FAIL no_hazard_x0: got %b/%b expected %b", ctl1, ctl2, C_NORM); n_bad++;
        end
        step();
        ex_rd = 5; id_rs2 = 5; id_use_rs2 = 0; id_rs1 = 6; id_use_rs1 = 1;
        @(negedge clk);
        n_cmp++;
        if (ctl1 !== C_NORM || ctl2 !== C_NORM) begin
            $display("FAIL no_hazard_unused: got %b/%b expected %b", ctl1, ctl2, C_NORM); n_bad++;
        end
        step();
        ex_mem_read = 0; ex_reg_write = 1; id_use_rs2 = 1;
        @(negedge clk);
        n_cmp++;
        if (ctl1 !== C_NORM || ctl2 !== C_NORM) begin
            $display("FAIL no_hazard_alu_nonbranch: got %b/%b expected %b", ctl1, ctl2, C_NORM); n_bad++;
        end
        step();
        idle();
        @(negedge clk);
        n_cmp++;
        if (scnt1 !== 3'd0 || scnt2 !== 16'd0) begin
            $display("FAIL no_hazard_cnt: got %0d/%0d expected 0/0", scnt1, scnt2); n_bad++;
        end
    endtask

    task automatic test_branch_stall();
        logic [4:0] e1 [4];
        logic [4:0] e2 [4];
        e1 = '{C_STALL, C_STALL, C_REDIR, C_REDIR};
        e2 = '{C_STALL, C_STALL, C_STALL, C_REDIR};
        do_reset();
        branch_load_hazard();
        id_branch_taken = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ctl1 !== e1[i] || ctl2 !== e2[i]) begin
                $display("FAIL branch_stall_c%0d: got %b/%b expected %b/%b", i, ctl1, ctl2, e1[i], e2[i]); n_bad++;
            end
            step();
            ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0;
        end
        idle();
        @(negedge clk);
        n_cmp++;
        if (scnt1 !== 3'd2 || scnt2 !== 16'd3 || flcnt1 !== 3'd2 || flcnt2 !== 16'd1) begin
            $display("FAIL branch_stall_cnt: got stall %0d/%0d flush %0d/%0d expected 2/3 2/1",
                     scnt1, scnt2, flcnt1, flcnt2); n_bad++;
        end
    endtask

    task automatic test_freeze();
        logic [4:0] e1 [8];
        logic [4:0] e2 [8];
        e1 = '{C_STALL, C_FRZ, C_FRZ, C_FRZ, C_FRZ, C_STALL, C_NORM, C_NORM};
        e2 = '{C_STALL, C_FRZ, C_FRZ, C_FRZ, C_FRZ, C_STALL, C_STALL, C_NORM};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            idle();
            if (i == 0) branch_load_hazard();
            dcache_stall = (i >= 1 && i <= 4);
            @(negedge clk);
            n_cmp++;
            if (ctl1 !== e1[i] || ctl2 !== e2[i]) begin
                $display("FAIL freeze_c%0d: got %b/%b expected %b/%b", i, ctl1, ctl2, e1[i], e2[i]); n_bad++;
            end
            step();
        end
        idle();
        @(negedge clk);
        n_cmp++;
        if (fzcnt1 !== 3'd4 || fzcnt2 !== 16'd4 || scnt1 !== 3'd2 || scnt2 !== 16'd3) begin
            $display("FAIL freeze_cnt: got freeze %0d/%0d stall %0d/%0d expected 4/4 2/3",
                     fzcnt1, fzcnt2, scnt1, scnt2); n_bad++;
        end
    endtask

    task automatic test_redirect();
        do_reset();
        id_branch_taken = 1; icache_stall = 1;
        @(negedge clk);
        n_cmp++;
        if (ctl1 !== C_REDIR || ctl2 !== C_REDIR) begin
            $display("FAIL redirect_over_icache: got %b/%b expected %b", ctl1, ctl2, C_REDIR); n_bad++;
        end
        step();
        id_branch_taken = 0;
        @(negedge clk);
        n_cmp++;
        if (ctl1 !== C_FBUB || ctl2 !== C_FBUB) begin
            $display("FAIL fetch_bubble: got %b/%b expected %b", ctl1, ctl2, C_FBUB); n_bad++;
        end
        step();
        idle();
        @(negedge clk);
        n_cmp++;
        if (flcnt1 !== 3'd1 || flcnt2 !== 16'd1 || scnt2 !== 16'd0) begin
            $display("FAIL redirect_cnt: got flush %0d/%0d stall %0d expected 1/1 0", flcnt1, flcnt2, scnt2); n_bad++;
        end
    endtask

    task automatic test_mid_stall_reset();
        do_reset();
        branch_load_hazard();
        @(negedge clk);
        n_cmp++;
        if (ctl2 !== C_STALL) begin
            $display("FAIL mid_reset_c0: got %b expected %b", ctl2, C_STALL); n_bad++;
        end
        step();
        idle();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ctl2 !== C_STALL || ctl1 !== C_STALL) begin
            $display("FAIL mid_reset_outputs: got %b/%b expected %b", ctl1, ctl2, C_STALL); n_bad++;
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ctl2 !== C_NORM || scnt2 !== 16'd0 || scnt1 !== 3'd0) begin
            $display("FAIL mid_reset_recover: got %b stall %0d/%0d expected %b 0/0", ctl2, scnt1, scnt2, C_NORM); n_bad++;
        end
        step();
    endtask

    task automatic test_cnt_clr();
        do_reset();
        id_branch_taken = 1;
        step();
        idle();
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1; cnt_clr = 1;
        @(negedge clk);
        n_cmp++;
        if (ctl1 !== C_STALL || flcnt1 !== 3'd1) begin
            $display("FAIL cnt_clr_pre: got %b flush %0d expected %b 1", ctl1, flcnt1, C_STALL); n_bad++;
        end
        step();
        idle();
        @(negedge clk);
        n_cmp++;
        if ({scnt1, fzcnt1, flcnt1} !== 9'd0 || {scnt2, fzcnt2, flcnt2} !== 48'd0) begin
            $display("FAIL cnt_clr_wins: got %0d %0d %0d / %0d %0d %0d expected all 0",
                     scnt1, fzcnt1, flcnt1, scnt2, fzcnt2, flcnt2); n_bad++;
        end
        step();
        @(negedge clk);
        n_cmp++;
        if (scnt2 !== 16'd1 || scnt1 !== 3'd0) begin
            $display("FAIL cnt_after_clr: got %0d/%0d expected 0/1", scnt1, scnt2); n_bad++;
        end
    endtask

    task automatic test_saturation();
        do_reset();
        id_branch_taken = 1;
        repeat (9) step();
        idle();
        @(negedge clk);
        n_cmp++;
        if (flcnt1 !== 3'd7 || flcnt2 !== 16'd9) begin
            $display("FAIL saturation: got %0d/%0d expected 7/9", flcnt1, flcnt2); n_bad++;
        end
    endtask

    task automatic test_single_cycle_branch();
        do_reset();
        id_is_branch = 1; ex_reg_write = 1; ex_rd = 3; id_rs2 = 3; id_use_rs2 = 1;
        @(negedge clk);
        n_cmp++;
        if (ctl1 !== C_STALL || ctl2 !== C_STALL) begin
            $display("FAIL branch_alu_ex: got %b/%b expected %b", ctl1, ctl2, C_STALL); n_bad++;
        end
        step();
        idle();
        id_is_branch = 1; mem_mem_read = 1; mem_rd = 4; id_rs1 = 4; id_use_rs1 = 1;
        @(negedge clk);
        n_cmp++;
        if (ctl1 !== C_STALL || ctl2 !== C_STALL) begin
            $display("FAIL branch_load_mem: got %b/%b expected %b", ctl1, ctl2, C_STALL); n_bad++;
        end
        step();
        mem_rd = 0; id_rs1 = 0;
        @(negedge clk);
        n_cmp++;
        if (ctl1 !== C_NORM || ctl2 !== C_NORM) begin
            $display("FAIL branch_mem_x0: got %b/%b expected %b", ctl1, ctl2, C_NORM); n_bad++;
        end
        step();
        idle();
        @(negedge clk);
        n_cmp++;
        if (scnt1 !== 3'd2 || scnt2 !== 16'd2 || ctl2 !== C_NORM) begin
            $display("FAIL branch_single_cnt: got %0d/%0d %b expected 2/2 %b", scnt1, scnt2, ctl2, C_NORM); n_bad++;
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch_stall();
        test_freeze();
        test_redirect();
        test_mid_stall_reset();
        test_cnt_clr();
        test_saturation();
        test_single_cycle_branch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
